flag_status_unit: RTL

FLAG_STATUS_UNIT -- requirements
Module: flag_status_unit

---
 rtl/flag_status_unit.sv | 113 +++++++++++
 1 files changed

// File: rtl/flag_status_unit.sv
// ============================================================================
// flag_status_unit -- {N,Z,C,V} status flags with a one-deep shadow register
// Revision 1.0 -- initial release
// ============================================================================
`default_nettype none

module flag_status_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_s,
  input  logic             ex_cond_pass,
  input  logic             ex_logic,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_c,
  input  logic             alu_v,
  input  logic             stall,
  input  logic             msr_we,
  input  logic [3:0]       msr_data,
  input  logic             save,
  input  logic             restore,
  output logic [3:0]       flags,
  output logic [3:0]       flags_fwd,
  output logic             shadow_valid,
  output logic             restore_err,
  output logic [15:0]      upd_cnt
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_SAVED = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  flags_q, flags_d;
  logic [3:0]  shadow_q, shadow_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rerr_q, rerr_d;

  logic [3:0]  alu_flags;
  logic        alu_upd;
  logic        restore_ok;
  logic        restore_bad;
  logic        save_ok;

  // Logical ops leave C and V as they were.
  assign alu_flags = {alu_res[WIDTH-1],
                      (alu_res == '0),
                      ex_logic ? flags_q[1] : alu_c,
                      ex_logic ? flags_q[0] : alu_v};

  assign alu_upd     = ex_valid & ex_s & ex_cond_pass & ~stall;
  assign restore_ok  = restore & ~stall & (state_q == ST_SAVED);
  assign restore_bad = restore & ~stall & (state_q == ST_EMPTY);
  assign save_ok     = save & ~stall;

  always_comb begin
    flags_d  = flags_q;
    shadow_d = shadow_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    rerr_d   = restore_bad;

    // A restore with nothing saved does not win; the next event down does.
    if (!stall) begin
      if (restore_ok) begin
        flags_d = shadow_q;
      end else if (msr_we) begin
        flags_d = msr_data;
      end else if (alu_upd) begin
        flags_d = alu_flags;
        if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
    end

    // Save captures pre-update flags; together with restore this is a swap.
    if (save_ok) begin
      shadow_d = flags_q;
      state_d  = ST_SAVED;
    end else if (restore_ok) begin
      state_d  = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_EMPTY;
      flags_q  <= 4'b0000;
      shadow_q <= 4'b0000;
      cnt_q    <= 16'd0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      rerr_q   <= rerr_d;
    end
  end

  assign flags        = flags_q;
  assign flags_fwd    = flags_d;
  assign shadow_valid = (state_q == ST_SAVED);
  assign restore_err  = rerr_q;
  assign upd_cnt      = cnt_q;

endmodule

`default_nettype wire
